// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU: single-cycle logic/arith/compare, bit-serial shifts, optional iterative multiply (ALU_EXEC_MUL_EN)
module alu_exec_unit #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
`ifdef ALU_EXEC_MUL_EN
  logic [XLEN-1:0] mplr_q, mplr_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] acc_next;
`endif

  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            is_mul;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [XLEN-1:0] shift_step;

  assign shamt    = op_b[SHW-1:0];
  assign is_shift = (alu_ctrl == 4'b0111) || (alu_ctrl == 4'b1000) || (alu_ctrl == 4'b1001);
`ifdef ALU_EXEC_MUL_EN
  assign is_mul   = (alu_ctrl == 4'b1010);
`else
  assign is_mul   = 1'b0;
`endif

  // Single-cycle result; shifts only reach here with a zero shift amount, so they pass op_a
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a ^ op_b;
      4'b0011: alu_res = op_a + op_b;
      4'b0100: alu_res = op_a - op_b;
      4'b0101: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0110: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'b0111, 4'b1000, 4'b1001: alu_res = op_a;
      default: alu_ill = 1'b1;
    endcase
  end

  // One-bit shift step for the serial shifter; SRA replicates the sign bit
  always_comb begin
    case (ctrl_q)
      4'b0111: shift_step = {data_q[XLEN-2:0], 1'b0};
      4'b1000: shift_step = {1'b0, data_q[XLEN-1:1]};
      default: shift_step = {data_q[XLEN-1], data_q[XLEN-1:1]};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mul)                          state_d = S_MUL;
          else if (is_shift && (shamt != '0)) state_d = S_SHIFT;
          else                                 state_d = S_DONE;
        end
      end
      S_SHIFT: if (cnt_q == CW'(1)) state_d = S_DONE;
`ifdef ALU_EXEC_MUL_EN
      S_MUL:   if (cnt_q == CW'(1)) state_d = S_DONE;
`endif
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath next-state: latch on accept, iterate in SHIFT/MUL, publish result on completion
  always_comb begin
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_MUL_EN
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    acc_next  = mplr_q[0] ? (acc_q + data_q) : acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ctrl_d = alu_ctrl;
          data_d = op_a;
          cnt_d  = CW'(shamt);
`ifdef ALU_EXEC_MUL_EN
          mplr_d = op_b;
          acc_d  = '0;
          if (is_mul) cnt_d = CW'(XLEN);
`endif
          if (!is_mul && !(is_shift && (shamt != '0))) begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
          end
        end
      end
      S_SHIFT: begin
        data_d = shift_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d  = shift_step;
          zero_d    = (shift_step == '0);
          illegal_d = 1'b0;
        end
      end
`ifdef ALU_EXEC_MUL_EN
      S_MUL: begin
        acc_d  = acc_next;
        data_d = {data_q[XLEN-2:0], 1'b0};
        mplr_d = {1'b0, mplr_q[XLEN-1:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d  = acc_next;
          zero_d    = (acc_next == '0);
          illegal_d = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers; reset clears the visible result and abandons any in-flight op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mplr_q    <= '0;
      acc_q     <= '0;
`endif
    end else begin
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
`endif
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule
